// File: rtl/memory_bus_responder_pkg.sv
// ---------------------------------------------------------------------------
// memory_bus_responder_pkg
// Shared MemoryBus definitions used by the memory-side responder and by
// anything that builds or decodes bus packets.
//   BusPacket            : kind / source / address / payload, packed
//   BusID                : identifier of the initiator that issued a packet
//   memory_address_t     : word address carried on the bus
//   bus_packet_payload_t : one data word
//   create_bus_packet()  : assembles a packet from its fields
// ---------------------------------------------------------------------------
package memory_bus_responder_pkg;

  localparam int BUS_ID_W  = 4;
  localparam int ADDR_W    = 16;
  localparam int PAYLOAD_W = 32;

  typedef logic [BUS_ID_W-1:0]  BusID;
  typedef logic [ADDR_W-1:0]    memory_address_t;
  typedef logic [PAYLOAD_W-1:0] bus_packet_payload_t;

  // Encoding 2'd3 is unused; a responder treats it as an illegal request.
  typedef enum logic [1:0] {
    bus_read_data     = 2'd0,
    bus_write_data    = 2'd1,
    bus_read_response = 2'd2
  } bus_packet_kind_t;

  typedef struct packed {
    bus_packet_kind_t    kind;
    BusID                source;
    memory_address_t     address;
    bus_packet_payload_t payload;
  } BusPacket;

  function automatic BusPacket create_bus_packet(
    input bus_packet_kind_t    kind,
    input BusID                source,
    input memory_address_t     address,
    input bus_packet_payload_t payload
  );
    BusPacket pkt;
    pkt.kind    = kind;
    pkt.source  = source;
    pkt.address = address;
    pkt.payload = payload;
    return pkt;
  endfunction

endpackage

// File: rtl/memory_bus_word_ram.sv
// ---------------------------------------------------------------------------
// memory_bus_word_ram
// Single-port synchronous word RAM behind the memory bus responder.
//   clk   : rising-edge clock
//   we    : write enable, writes wdata into word idx at the clock edge
//   idx   : word index (log2(DEPTH) bits)
//   wdata : write data
//   rdata : registered read data, mem[idx] one cycle after idx is presented
// Contents are deliberately not reset.
// ---------------------------------------------------------------------------
module memory_bus_word_ram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // The read port samples every cycle; the responder keeps idx constant for
  // the whole transaction, so rdata is settled by the time the FSM leaves
  // ACCESS and stays put while the response is pending.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[idx] <= wdata;
    end
    rdata <= r_mem[idx];
  end

endmodule

// File: rtl/memory_bus_responder.sv
// ---------------------------------------------------------------------------
// memory_bus_responder
// Memory-side end of the MemoryBus request/response protocol. Takes one
// request at a time from the bus request slot, services it against a local
// word array and, for reads, returns a bus_read_response packet.
//   clk        : system clock, rising edge
//   reset_n    : asynchronous active-low reset
//   req_busy   : request slot holds a valid packet
//   req_data   : request packet
//   req_accept : 1-cycle pulse, the request was taken
//   resp_busy  : response slot occupied
//   resp_data  : response packet, valid while resp_send is high
//   resp_send  : 1-cycle pulse, response slot should be filled
//   idle       : FSM is in IDLE
//   err_count  : saturating count of dropped or illegal requests
// ---------------------------------------------------------------------------
module memory_bus_responder
  import memory_bus_responder_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2,
  parameter int ERR_W   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_busy,
  input  BusPacket         req_data,
  output logic             req_accept,
  input  logic             resp_busy,
  output BusPacket         resp_data,
  output logic             resp_send,
  output logic             idle,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESPOND
  } responder_state_t;

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LAT_W = $clog2(LATENCY + 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATENCY - 1);

  responder_state_t r_state;
  responder_state_t w_nextState;

  BusPacket            r_pktQ;
  logic [LAT_W-1:0]    r_latCnt;
  logic                r_reqAccept;
  logic                r_respSend;
  logic [ERR_W-1:0]    r_errCount;

  logic                w_accept;
  logic                w_ramWe;
  logic                w_errInc;
  logic                w_respFire;
  logic                w_outOfRange;
  logic [IDX_W-1:0]    w_idx;
  bus_packet_payload_t w_ramRdata;
  bus_packet_payload_t w_rdata;

  // Index truncation is explicit: the low address bits pick the word, and
  // any bit above them marks the request as out of range.
  assign w_idx        = r_pktQ.address[IDX_W-1:0];
  assign w_outOfRange = (r_pktQ.address >> IDX_W) != '0;

  memory_bus_word_ram #(
    .DEPTH (DEPTH),
    .WIDTH (PAYLOAD_W)
  ) wordRam (
    .clk   (clk),
    .we    (w_ramWe),
    .idx   (w_idx),
    .wdata (r_pktQ.payload),
    .rdata (w_ramRdata)
  );

  // Next-state and per-cycle control. The access itself happens in the last
  // ACCESS cycle (lat_cnt == 0); the write enable comes straight from the
  // state register, so an asynchronous reset in that cycle kills the write.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_ramWe     = 1'b0;
    w_errInc    = 1'b0;
    w_respFire  = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_busy) begin
          w_accept    = 1'b1;
          w_nextState = ACCESS;
        end
      end
      ACCESS: begin
        if (r_latCnt == '0) begin
          case (r_pktQ.kind)
            bus_read_data: begin
              w_errInc    = w_outOfRange;
              w_nextState = RESPOND;
            end
            bus_write_data: begin
              w_ramWe     = !w_outOfRange;
              w_errInc    = w_outOfRange;
              w_nextState = IDLE;
            end
            default: begin
              w_errInc    = 1'b1;
              w_nextState = IDLE;
            end
          endcase
        end
      end
      RESPOND: begin
        if (!resp_busy) begin
          w_respFire  = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State, latched request, latency counter, output pulses and the error
  // counter. The counter saturates at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_pktQ      <= '0;
      r_latCnt    <= '0;
      r_reqAccept <= 1'b0;
      r_respSend  <= 1'b0;
      r_errCount  <= '0;
    end else begin
      r_state     <= w_nextState;
      r_reqAccept <= w_accept;
      r_respSend  <= w_respFire;
      if (w_accept) begin
        r_pktQ   <= req_data;
        r_latCnt <= LAT_LOAD;
      end else if (r_state == ACCESS && r_latCnt != '0) begin
        r_latCnt <= r_latCnt - LAT_W'(1);
      end
      if (w_errInc && r_errCount != '1) begin
        r_errCount <= r_errCount + ERR_W'(1);
      end
    end
  end

  // Response packet. The latched request and the RAM read port do not move
  // until the next accept, so the packet is stable through RESPOND and the
  // resp_send cycle; it is zero otherwise, including during reset.
  always_comb begin
    w_rdata   = w_outOfRange ? '0 : w_ramRdata;
    resp_data = '0;
    if (r_state == RESPOND || r_respSend) begin
      resp_data = create_bus_packet(bus_read_response, r_pktQ.source, '0, w_rdata);
    end
  end

  assign req_accept = r_reqAccept;
  assign resp_send  = r_respSend;
  assign idle       = (r_state == IDLE);
  assign err_count  = r_errCount;

endmodule

// File: tb/tb_memory_bus_responder.sv
// ---------------------------------------------------------------------------
// tb_memory_bus_responder
// Directed bench for memory_bus_responder. A second instance with a 2-bit
// error counter receives the same stimulus to exercise counter saturation.
// ---------------------------------------------------------------------------
module tb_memory_bus_responder;
  import memory_bus_responder_pkg::*;

  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;
  localparam int ERR_W   = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             req_busy;
  BusPacket         req_data;
  logic             req_accept;
  logic             resp_busy;
  BusPacket         resp_data;
  logic             resp_send;
  logic             idle;
  logic [ERR_W-1:0] err_count;

  logic             satReqAccept;
  BusPacket         satRespData;
  logic             satRespSend;
  logic             satIdle;
  logic [1:0]       satErrCount;

  int       total = 0;
  int       bad = 0;
  int       acceptCount = 0;
  int       respCount = 0;
  BusPacket respLog [$];

  memory_bus_responder #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY),
    .ERR_W   (ERR_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_busy   (req_busy),
    .req_data   (req_data),
    .req_accept (req_accept),
    .resp_busy  (resp_busy),
    .resp_data  (resp_data),
    .resp_send  (resp_send),
    .idle       (idle),
    .err_count  (err_count)
  );

  memory_bus_responder #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY),
    .ERR_W   (2)
  ) dutSat (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_busy   (req_busy),
    .req_data   (req_data),
    .req_accept (satReqAccept),
    .resp_busy  (resp_busy),
    .resp_data  (satRespData),
    .resp_send  (satRespSend),
    .idle       (satIdle),
    .err_count  (satErrCount)
  );

  always #5 clk = ~clk;

  // Count accept and response pulses mid-cycle and log every response.
  always @(negedge clk) begin
    if (req_accept) acceptCount++;
    if (resp_send) begin
      respCount++;
      respLog.push_back(resp_data);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time=%0t limit=%0t", $time, 100000);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until the responder accepts it.
  task automatic applyStimulus(input string tag, input bus_packet_kind_t kind, input BusID src,
                               input memory_address_t addr, input bus_packet_payload_t data);
    logic seen = 1'b0;
    req_data = create_bus_packet(kind, src, addr, data);
    req_busy = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (req_accept) seen = 1'b1;
    end
    req_busy = 1'b0;
    checkOutput({tag, "_accept"}, 64'(seen), 64'd1);
  endtask

  // Called right after an accept; lat = cycles until resp_send is seen.
  task automatic waitResponse(input string tag, output int lat);
    lat = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      tick();
      if (resp_send) lat = i;
    end
    checkOutput({tag, "_resp_seen"}, 64'(lat != 0), 64'd1);
  endtask

  initial begin
    int       lat;
    int       acc0;
    int       resp0;
    int       log0;
    int       seqIdx;
    logic     holdBad;
    BusPacket snap;
    BusPacket r0;
    BusPacket r1;
    BusPacket seq [3];

    reset_n   = 1'b0;
    req_busy  = 1'b0;
    req_data  = '0;
    resp_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    checkOutput("rst_idle", idle, 1);
    checkOutput("rst_accept", req_accept, 0);
    checkOutput("rst_send", resp_send, 0);
    checkOutput("rst_resp_data", resp_data, 0);
    checkOutput("rst_err", err_count, 0);
    checkOutput("rst_sat_err", satErrCount, 0);
    reset_n = 1'b1;
    tick();

    // Known contents for the out-of-range checks later on
    applyStimulus("pre0", bus_write_data, 4'd0, 16'd0, 32'h1111_1111);
    applyStimulus("pre1", bus_write_data, 4'd0, 16'd1, 32'h2222_2222);
    repeat (3) tick();

    // 1: write then read back
    acc0  = acceptCount;
    resp0 = respCount;
    applyStimulus("t1_wr", bus_write_data, 4'd2, 16'd5, 32'h0000_00A5);
    applyStimulus("t1_rd", bus_read_data, 4'd3, 16'd5, 32'h0);
    waitResponse("t1_rd", lat);
    checkOutput("t1_latency", 64'(lat), 64'(LATENCY + 1));
    checkOutput("t1_kind", resp_data.kind, bus_read_response);
    checkOutput("t1_source", resp_data.source, 3);
    checkOutput("t1_payload", resp_data.payload, 32'h0000_00A5);
    tick();
    checkOutput("t1_accepts", 64'(acceptCount - acc0), 2);
    checkOutput("t1_resps", 64'(respCount - resp0), 1);

    // 2: response slot busy for 10 cycles, second request waiting in the slot
    acc0      = acceptCount;
    resp0     = respCount;
    resp_busy = 1'b1;
    applyStimulus("t2_rd", bus_read_data, 4'd9, 16'd5, 32'h0);
    req_data = create_bus_packet(bus_write_data, 4'd1, 16'd6, 32'h0000_0066);
    req_busy = 1'b1;
    tick();
    tick();
    snap    = resp_data;
    holdBad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (resp_send || req_accept || idle || resp_data !== snap) holdBad = 1'b1;
    end
    checkOutput("t2_hold", holdBad, 0);
    checkOutput("t2_snap_payload", snap.payload, 32'h0000_00A5);
    checkOutput("t2_snap_source", snap.source, 9);
    resp_busy = 1'b0;
    tick();
    checkOutput("t2_send", resp_send, 1);
    checkOutput("t2_payload", resp_data.payload, 32'h0000_00A5);
    tick();
    checkOutput("t2_next_accept", req_accept, 1);
    req_busy = 1'b0;
    tick();
    checkOutput("t2_accepts", 64'(acceptCount - acc0), 2);
    checkOutput("t2_resps", 64'(respCount - resp0), 1);
    repeat (3) tick();

    // 3: back-to-back with req_busy held high, new packet after each accept
    seq[0] = create_bus_packet(bus_write_data, 4'd0, 16'd8, 32'h0000_0088);
    seq[1] = create_bus_packet(bus_read_data, 4'd1, 16'd8, 32'h0);
    seq[2] = create_bus_packet(bus_read_data, 4'd2, 16'd5, 32'h0);
    acc0   = acceptCount;
    resp0  = respCount;
    log0   = respLog.size();
    seqIdx = 0;
    req_data = seq[0];
    req_busy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (req_accept && seqIdx < 3) begin
        seqIdx++;
        if (seqIdx < 3) req_data = seq[seqIdx];
        else req_busy = 1'b0;
      end
    end
    req_busy = 1'b0;
    tick();
    r0 = (respLog.size() > log0) ? respLog[log0] : '0;
    r1 = (respLog.size() > log0 + 1) ? respLog[log0 + 1] : '0;
    checkOutput("t3_accepts", 64'(acceptCount - acc0), 3);
    checkOutput("t3_resps", 64'(respCount - resp0), 2);
    checkOutput("t3_r0_payload", r0.payload, 32'h0000_0088);
    checkOutput("t3_r0_source", r0.source, 1);
    checkOutput("t3_r1_payload", r1.payload, 32'h0000_00A5);
    checkOutput("t3_r1_source", r1.source, 2);

    // 4: out-of-range read and write
    applyStimulus("t4_rd", bus_read_data, 4'd4, 16'(DEPTH), 32'h0);
    waitResponse("t4_rd", lat);
    checkOutput("t4_rd_payload", resp_data.payload, 0);
    applyStimulus("t4_wr", bus_write_data, 4'd4, 16'(DEPTH + 1), 32'h0000_DEAD);
    repeat (3) tick();
    checkOutput("t4_err", err_count, 2);
    checkOutput("t4_sat_err", satErrCount, 2);
    applyStimulus("t4_rd0", bus_read_data, 4'd4, 16'd0, 32'h0);
    waitResponse("t4_rd0", lat);
    checkOutput("t4_mem0", resp_data.payload, 32'h1111_1111);
    applyStimulus("t4_rd1", bus_read_data, 4'd4, 16'd1, 32'h0);
    waitResponse("t4_rd1", lat);
    checkOutput("t4_mem1", resp_data.payload, 32'h2222_2222);
    tick();

    // 5: illegal kind on the request channel, then saturation of the 2-bit counter
    acc0  = acceptCount;
    resp0 = respCount;
    applyStimulus("t5_bad", bus_read_response, 4'd5, 16'd5, 32'h0000_0055);
    repeat (6) tick();
    checkOutput("t5_accepts", 64'(acceptCount - acc0), 1);
    checkOutput("t5_resps", 64'(respCount - resp0), 0);
    checkOutput("t5_err", err_count, 3);
    checkOutput("t5_sat_err", satErrCount, 3);
    checkOutput("t5_idle", idle, 1);
    applyStimulus("t5_bad2", bus_read_response, 4'd5, 16'd5, 32'h0000_0055);
    repeat (4) tick();
    checkOutput("t5_err2", err_count, 4);
    checkOutput("t5_sat_hold", satErrCount, 3);

    // 6: reset during the access cycle of a write
    applyStimulus("t6_pre", bus_write_data, 4'd6, 16'd7, 32'h0000_0077);
    applyStimulus("t6_wr", bus_write_data, 4'd6, 16'd7, 32'h0000_0BAD);
    tick();
    reset_n = 1'b0;
    #1;
    checkOutput("t6_idle", idle, 1);
    checkOutput("t6_accept", req_accept, 0);
    checkOutput("t6_send", resp_send, 0);
    checkOutput("t6_resp_data", resp_data, 0);
    checkOutput("t6_err", err_count, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    applyStimulus("t6_rd", bus_read_data, 4'd6, 16'd7, 32'h0);
    waitResponse("t6_rd", lat);
    checkOutput("t6_mem7", resp_data.payload, 32'h0000_0077);
    checkOutput("t6_source", resp_data.source, 6);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
